// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single data_memory port between two requesters:
//   r0 = core load/store unit, r1 = DMA/debug loader.
//   A request accepted in IDLE is latched and driven onto the memory for
//   exactly one ACCESS cycle. Read data is captured at the end of ACCESS, and
//   the owner gets a one-cycle response pulse in RESP.
//   Latency: accept at edge T -> ACCESS cycle T+1 -> rsp_valid in cycle T+2.
//
// Parameters
//   DATA_WIDTH   data width of requests and the memory port
//   ADDR_WIDTH   byte address width (>= 2)
//   FIXED_PRIO   0 = round-robin, 1 = r0 always wins ties
//
// Ports
//   clk, rstn                    clock, asynchronous active-low reset
//   rN_req_valid / rN_req_ready  request handshake (N = 0,1)
//   rN_we, rN_maskmode, rN_sext  store select, 00 byte/01 half/10 word, load ext
//   rN_addr, rN_wdata            byte address, store data
//   rN_rsp_valid                 one-cycle completion pulse
//   rN_rsp_rdata                 load data (0 for stores), held between pulses
//   rN_rsp_err                   misaligned-access flag
//   mem_*                        data_memory port, all zero outside ACCESS
//
// Build option
//   DMEM_ARB_MISALIGN_CHECK_EN   when defined, misaligned half/word accesses
//                                do not touch memory and respond with
//                                rsp_err=1 and rsp_rdata=0
// -----------------------------------------------------------------------------
// state  | meaning
// IDLE   | arbitrate, accept one request
// ACCESS | latched request is on the memory port for one cycle
// RESP   | owner's rsp_valid pulse, captured data on rsp_rdata
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  r0_req_valid,
  output logic                  r0_req_ready,
  input  logic                  r0_we,
  input  logic [1:0]            r0_maskmode,
  input  logic                  r0_sext,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_rsp_valid,
  output logic [DATA_WIDTH-1:0] r0_rsp_rdata,
  output logic                  r0_rsp_err,
  input  logic                  r1_req_valid,
  output logic                  r1_req_ready,
  input  logic                  r1_we,
  input  logic [1:0]            r1_maskmode,
  input  logic                  r1_sext,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_rsp_valid,
  output logic [DATA_WIDTH-1:0] r1_rsp_rdata,
  output logic                  r1_rsp_err,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [1:0]            mem_maskmode,
  output logic                  mem_sext,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]            r_state;
  logic                  r_rr_ptr;
  logic                  r_owner;
  logic                  r_we;
  logic [1:0]            r_maskmode;
  logic                  r_sext;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;

  logic                  w_idle;
  logic                  w_access;
  logic                  w_resp;
  logic                  w_accept;
  logic                  w_grant_id;
  logic                  w_misalign;
  logic [DATA_WIDTH-1:0] w_capture;

  assign w_idle   = (r_state == S_IDLE);
  assign w_access = (r_state == S_ACCESS);
  assign w_resp   = (r_state == S_RESP);

  // Tie goes to rr_ptr (or r0 when fixed); a lone requester always wins.
  always_comb begin
    w_grant_id = 1'b0;
    if (r0_req_valid && r1_req_valid)
      w_grant_id = FIXED_PRIO ? 1'b0 : r_rr_ptr;
    else if (r1_req_valid)
      w_grant_id = 1'b1;
  end

  assign w_accept     = w_idle && (r0_req_valid || r1_req_valid);
  assign r0_req_ready = w_idle && r0_req_valid && !w_grant_id;
  assign r1_req_ready = w_idle && r1_req_valid &&  w_grant_id;

`ifdef DMEM_ARB_MISALIGN_CHECK_EN
  logic r_err;

  assign w_misalign = ((r_maskmode == 2'b01) && r_addr[0]) ||
                      ((r_maskmode == 2'b10) && (r_addr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_err <= 1'b0;
    else if (w_access)
      r_err <= w_misalign;
  end

  assign r0_rsp_err = w_resp && !r_owner && r_err;
  assign r1_rsp_err = w_resp &&  r_owner && r_err;
`else
  assign w_misalign = 1'b0;
  assign r0_rsp_err = 1'b0;
  assign r1_rsp_err = 1'b0;
`endif

  // Memory port is purely decoded from state, so an async reset during
  // ACCESS drops mem_write immediately, before the memory's negedge commit.
  assign mem_write      = w_access &&  r_we && !w_misalign;
  assign mem_read       = w_access && !r_we && !w_misalign;
  assign mem_maskmode   = w_access ? r_maskmode : 2'b00;
  assign mem_sext       = w_access && r_sext;
  assign mem_address    = w_access ? r_addr  : '0;
  assign mem_write_data = w_access ? r_wdata : '0;

  assign w_capture = (r_we || w_misalign) ? '0 : mem_read_data;

  assign r0_rsp_valid = w_resp && !r_owner;
  assign r1_rsp_valid = w_resp &&  r_owner;
  assign r0_rsp_rdata = r_rdata0;
  assign r1_rsp_rdata = r_rdata1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= 1'b0;
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_maskmode <= 2'b00;
      r_sext     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_owner    <= w_grant_id;
            r_rr_ptr   <= !w_grant_id;
            r_we       <= w_grant_id ? r1_we       : r0_we;
            r_maskmode <= w_grant_id ? r1_maskmode : r0_maskmode;
            r_sext     <= w_grant_id ? r1_sext     : r0_sext;
            r_addr     <= w_grant_id ? r1_addr     : r0_addr;
            r_wdata    <= w_grant_id ? r1_wdata    : r0_wdata;
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_owner)
            r_rdata1 <= w_capture;
          else
            r_rdata0 <= w_capture;
          r_state <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam bit FIXED_PRIO = 1'b0;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic r0_req_valid = 1'b0, r0_we = 1'b0, r0_sext = 1'b0;
  logic [1:0] r0_maskmode = 2'b00;
  logic [AW-1:0] r0_addr = '0;
  logic [DW-1:0] r0_wdata = '0;
  logic r0_req_ready, r0_rsp_valid, r0_rsp_err;
  logic [DW-1:0] r0_rsp_rdata;
  logic r1_req_valid = 1'b0, r1_we = 1'b0, r1_sext = 1'b0;
  logic [1:0] r1_maskmode = 2'b00;
  logic [AW-1:0] r1_addr = '0;
  logic [DW-1:0] r1_wdata = '0;
  logic r1_req_ready, r1_rsp_valid, r1_rsp_err;
  logic [DW-1:0] r1_rsp_rdata;
  logic mem_write, mem_read, mem_sext;
  logic [1:0] mem_maskmode;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;

  bit [31:0] mem [256];
  bit [7:0]  shadow [1024];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIXED_PRIO(FIXED_PRIO)) dut (
    .clk(clk), .rstn(rstn),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_we(r0_we),
    .r0_maskmode(r0_maskmode), .r0_sext(r0_sext), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata), .r0_rsp_err(r0_rsp_err),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_we(r1_we),
    .r1_maskmode(r1_maskmode), .r1_sext(r1_sext), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata), .r1_rsp_err(r1_rsp_err),
    .mem_write(mem_write), .mem_read(mem_read), .mem_maskmode(mem_maskmode),
    .mem_sext(mem_sext), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  // data_memory stand-in: combinational read, negedge write, sext=0 sign-extends
  always_comb begin
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = mem[mem_address[9:2]];
    b = w[{mem_address[1:0], 3'b000} +: 8];
    h = mem_address[1] ? w[31:16] : w[15:0];
    mem_read_data = '0;
    if (mem_read) begin
      case (mem_maskmode)
        2'b00:   mem_read_data = mem_sext ? {24'h0, b} : {{24{b[7]}}, b};
        2'b01:   mem_read_data = mem_sext ? {16'h0, h} : {{16{h[15]}}, h};
        2'b10:   mem_read_data = w;
        default: mem_read_data = '0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (mem_write) begin
      case (mem_maskmode)
        2'b00: mem[mem_address[9:2]][{mem_address[1:0], 3'b000} +: 8] = mem_write_data[7:0];
        2'b01: if (mem_address[1]) mem[mem_address[9:2]][31:16] = mem_write_data[15:0];
               else                mem[mem_address[9:2]][15:0]  = mem_write_data[15:0];
        2'b10: mem[mem_address[9:2]] = mem_write_data;
        default: ;
      endcase
    end
  end

  // ---------------- reference model (byte-addressed, little-endian) ----------
  function automatic bit misal(logic [1:0] mm, logic [31:0] a);
    bit m;
    m = ((mm == 2'b01) && a[0]) || ((mm == 2'b10) && (a[1:0] != 2'b00));
    return MIS_EN && m;
  endfunction

  function automatic void model_store(logic [1:0] mm, logic [31:0] a, logic [31:0] d);
    int base;
    base = int'(a[9:0]);
    if (misal(mm, a)) return;
    case (mm)
      2'b00: shadow[base] = d[7:0];
      2'b01: begin
        base = base & ~1;
        shadow[base] = d[7:0];
        shadow[base + 1] = d[15:8];
      end
      2'b10: begin
        base = base & ~3;
        for (int i = 0; i < 4; i++) shadow[base + i] = d[8*i +: 8];
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_load(logic [1:0] mm, logic [31:0] a, bit sx);
    int base;
    logic [31:0] v;
    base = int'(a[9:0]);
    v = 32'h0;
    if (misal(mm, a)) return 32'h0;
    case (mm)
      2'b00: begin
        v = {24'h0, shadow[base]};
        if (!sx && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'b01: begin
        base = base & ~1;
        v = {16'h0, shadow[base + 1], shadow[base]};
        if (!sx && v[15]) v = v | 32'hFFFF_0000;
      end
      2'b10: begin
        base = base & ~3;
        v = {shadow[base + 3], shadow[base + 2], shadow[base + 1], shadow[base]};
      end
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  // ---------------- per-requester access helpers -----------------------------
  task automatic drive_req(input int n, input bit we, input logic [1:0] mm, input bit sx,
                           input logic [31:0] a, input logic [31:0] d);
    if (n == 0) begin
      r0_req_valid = 1'b1; r0_we = we; r0_maskmode = mm; r0_sext = sx; r0_addr = a; r0_wdata = d;
    end else begin
      r1_req_valid = 1'b1; r1_we = we; r1_maskmode = mm; r1_sext = sx; r1_addr = a; r1_wdata = d;
    end
  endtask

  task automatic drop_req(input int n);
    if (n == 0) r0_req_valid = 1'b0;
    else        r1_req_valid = 1'b0;
  endtask

  function automatic logic rdy(int n);   return (n == 0) ? r0_req_ready : r1_req_ready; endfunction
  function automatic logic rsp_v(int n); return (n == 0) ? r0_rsp_valid : r1_rsp_valid; endfunction
  function automatic logic rsp_e(int n); return (n == 0) ? r0_rsp_err   : r1_rsp_err;   endfunction
  function automatic logic [31:0] rsp_d(int n); return (n == 0) ? r0_rsp_rdata : r1_rsp_rdata; endfunction

  // One complete transaction; entered and left at posedge+1.
  task automatic do_txn(input string nm, input int n, input bit we, input logic [1:0] mm,
                        input bit sx, input logic [31:0] a, input logic [31:0] d);
    int waitc;
    logic [31:0] exp_d;
    bit exp_e;
    waitc = 0;
    drive_req(n, we, mm, sx, a, d);
    #1;
    while (!rdy(n) && waitc < 20) begin
      @(posedge clk); #2; waitc++;
    end
    vectors++;
    if (rdy(n) !== 1'b1) begin
      $display("FAIL %s ready_timeout got=%b want=1", nm, rdy(n));
      miscompares++;
      drop_req(n);
      return;
    end
    exp_e = misal(mm, a);
    exp_d = we ? 32'h0 : model_load(mm, a, sx);
    if (we) model_store(mm, a, d);
    @(posedge clk); #1;
    drop_req(n);
    vectors++;
    if (mem_write !== (we && !exp_e) || mem_read !== (!we && !exp_e) ||
        mem_address !== a || mem_maskmode !== mm || (we && mem_write_data !== d)) begin
      $display("FAIL %s access got we=%b rd=%b addr=%h mm=%b wd=%h want we=%b rd=%b addr=%h mm=%b wd=%h",
               nm, mem_write, mem_read, mem_address, mem_maskmode, mem_write_data,
               we && !exp_e, !we && !exp_e, a, mm, d);
      miscompares++;
    end
    @(posedge clk); #1;
    vectors++;
    if (rsp_v(n) !== 1'b1 || rsp_v(1 - n) !== 1'b0) begin
      $display("FAIL %s rsp_valid got own=%b other=%b want own=1 other=0", nm, rsp_v(n), rsp_v(1 - n));
      miscompares++;
    end
    vectors++;
    if (rsp_d(n) !== exp_d) begin
      $display("FAIL %s rdata got=%h want=%h", nm, rsp_d(n), exp_d);
      miscompares++;
    end
    vectors++;
    if (rsp_e(n) !== exp_e) begin
      $display("FAIL %s rsp_err got=%b want=%b", nm, rsp_e(n), exp_e);
      miscompares++;
    end
    @(posedge clk); #1;
    vectors++;
    if (rsp_v(n) !== 1'b0) begin
      $display("FAIL %s rsp_pulse_width got=%b want=0", nm, rsp_v(n));
      miscompares++;
    end
  endtask

  // ---------------- scenarios ------------------------------------------------
  task automatic test_reset();
    rstn = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({mem_write, mem_read, mem_sext, mem_maskmode} !== 5'b0 || mem_address !== '0 || mem_write_data !== '0) begin
      $display("FAIL reset_mem got we=%b rd=%b addr=%h want all 0", mem_write, mem_read, mem_address);
      miscompares++;
    end
    vectors++;
    if ({r0_rsp_valid, r1_rsp_valid, r0_rsp_err, r1_rsp_err} !== 4'b0 || r0_rsp_rdata !== '0 || r1_rsp_rdata !== '0) begin
      $display("FAIL reset_rsp got v=%b%b d0=%h d1=%h want 0", r0_rsp_valid, r1_rsp_valid, r0_rsp_rdata, r1_rsp_rdata);
      miscompares++;
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    do_txn("st_word_40", 0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);
    do_txn("ld_word_40", 0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    vectors++;
    if (r0_rsp_rdata !== 32'hDEADBEEF) begin
      $display("FAIL ld_word_hold got=%h want=deadbeef", r0_rsp_rdata);
      miscompares++;
    end
  endtask

  task automatic test_byte_sext();
    do_txn("st_byte_10", 1, 1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_0080);
    do_txn("ld_byte_sx0", 1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    vectors++;
    if (r1_rsp_rdata !== 32'hFFFF_FF80) begin
      $display("FAIL ld_byte_sx0_const got=%h want=ffffff80", r1_rsp_rdata);
      miscompares++;
    end
    do_txn("ld_byte_sx1", 0, 1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    do_txn("mm11_store", 0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFF_FFFF);
    do_txn("ld_byte_after_mm11", 0, 1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
  endtask

  task automatic test_round_robin();
    int last_c;
    int k;
    int g;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    drive_req(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    drive_req(1, 1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    k = 0;
    last_c = -3;
    for (int c = 0; c < 20 && k < 4; c++) begin
      #1;
      if (r0_req_ready || r1_req_ready) begin
        g = r1_req_ready ? 1 : 0;
        vectors++;
        if ((r0_req_ready && r1_req_ready) || g != (FIXED_PRIO ? 0 : (k % 2)) || (c - last_c) != 3) begin
          $display("FAIL rr_grant%0d got id=%0d gap=%0d both=%b want id=%0d gap=3 both=0",
                   k, g, c - last_c, r0_req_ready && r1_req_ready, FIXED_PRIO ? 0 : (k % 2));
          miscompares++;
        end
        last_c = c;
        k++;
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (k != 4) begin
      $display("FAIL rr_grant_count got=%0d want=4", k);
      miscompares++;
    end
    drop_req(0);
    drop_req(1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_drop_valid();
    int waitc;
    logic [31:0] exp_d;
    waitc = 0;
    exp_d = model_load(2'b10, 32'h40, 1'b0);
    drive_req(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    #1;
    while (!r0_req_ready && waitc < 20) begin
      @(posedge clk); #2; waitc++;
    end
    @(posedge clk); #1;
    drop_req(0);
    drive_req(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    #1;
    vectors++;
    if (r1_req_ready !== 1'b0) begin
      $display("FAIL drop_ready_in_access got=%b want=0", r1_req_ready);
      miscompares++;
    end
    @(posedge clk); #1;
    drop_req(1);
    vectors++;
    if (r0_rsp_valid !== 1'b1 || r0_rsp_rdata !== exp_d || r1_rsp_valid !== 1'b0) begin
      $display("FAIL drop_owner_rsp got v0=%b d0=%h v1=%b want v0=1 d0=%h v1=0",
               r0_rsp_valid, r0_rsp_rdata, r1_rsp_valid, exp_d);
      miscompares++;
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (r1_rsp_valid !== 1'b0 || r0_rsp_valid !== 1'b0) begin
        $display("FAIL drop_no_rsp%0d got v0=%b v1=%b want 0 0", i, r0_rsp_valid, r1_rsp_valid);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid_access();
    int waitc;
    logic [31:0] exp_w;
    waitc = 0;
    exp_w = model_load(2'b10, 32'h20, 1'b0);
    drive_req(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
    #1;
    while (!r0_req_ready && waitc < 20) begin
      @(posedge clk); #2; waitc++;
    end
    @(posedge clk); #1;
    drop_req(0);
    vectors++;
    if (mem_write !== 1'b1) begin
      $display("FAIL rst_mid_write_before got=%b want=1", mem_write);
      miscompares++;
    end
    rstn = 1'b0;
    #1;
    vectors++;
    if (mem_write !== 1'b0) begin
      $display("FAIL rst_mid_write_drop got=%b want=0", mem_write);
      miscompares++;
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    vectors++;
    if (mem[8] !== exp_w) begin
      $display("FAIL rst_mid_word got=%h want=%h", mem[8], exp_w);
      miscompares++;
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (r0_rsp_valid !== 1'b0) begin
        $display("FAIL rst_mid_no_rsp%0d got=%b want=0", i, r0_rsp_valid);
        miscompares++;
      end
      @(posedge clk); #1;
    end
    drive_req(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    #1;
    vectors++;
    if (r1_req_ready !== 1'b1) begin
      $display("FAIL rst_mid_idle_ready got=%b want=1", r1_req_ready);
      miscompares++;
    end
    drop_req(1);
    @(posedge clk); #1;
  endtask

  task automatic test_misalign();
    do_txn("mis_st_word_22", 0, 1'b1, 2'b10, 1'b0, 32'h22, 32'hCAFEF00D);
    vectors++;
    if (mem[8] !== {shadow[35], shadow[34], shadow[33], shadow[32]} ||
        mem[8] !== (MIS_EN ? model_load(2'b10, 32'h20, 1'b0) : 32'hCAFEF00D)) begin
      $display("FAIL mis_word_20 got=%h want=%h", mem[8], {shadow[35], shadow[34], shadow[33], shadow[32]});
      miscompares++;
    end
    do_txn("mis_ld_half_41", 1, 1'b0, 2'b01, 1'b0, 32'h41, 32'h0);
  endtask

  task automatic test_random();
    bit          pend [2];
    bit          we [2];
    bit          sx [2];
    logic [1:0]  mm [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [31:0] exp_d [2];
    bit          exp_e [2];
    int busy;
    int owner;
    int w;
    bit pref;
    bit acc;
    busy = 0; owner = 0; pref = 1'b0;
    for (int n = 0; n < 2; n++) begin
      pend[n] = 1'b0; exp_d[n] = 32'h0; exp_e[n] = 1'b0;
    end
    drop_req(0);
    drop_req(1);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && $urandom_range(0, 3) != 0) begin
          pend[n] = 1'b1;
          we[n] = 1'($urandom_range(0, 1));
          mm[n] = 2'($urandom_range(0, 3));
          sx[n] = 1'($urandom_range(0, 1));
          a[n]  = 32'($urandom_range(0, 1023));
          d[n]  = $urandom;
          drive_req(n, we[n], mm[n], sx[n], a[n], d[n]);
        end
      end
      #1;
      acc = (busy == 0) && (pend[0] || pend[1]);
      w = (pend[0] && pend[1]) ? (FIXED_PRIO ? 0 : (pref ? 1 : 0)) : (pend[1] ? 1 : 0);
      vectors++;
      if (r0_req_ready !== (acc && w == 0) || r1_req_ready !== (acc && w == 1)) begin
        $display("FAIL rnd_ready c%0d got=%b%b want=%b%b", cyc, r1_req_ready, r0_req_ready,
                 acc && w == 1, acc && w == 0);
        miscompares++;
      end
      for (int n = 0; n < 2; n++) begin
        vectors++;
        if (rsp_v(n) !== (busy == 1 && owner == n)) begin
          $display("FAIL rnd_rsp_valid%0d c%0d got=%b want=%b", n, cyc, rsp_v(n), busy == 1 && owner == n);
          miscompares++;
        end
        if (busy == 1 && owner == n) begin
          vectors++;
          if (rsp_d(n) !== exp_d[n] || rsp_e(n) !== exp_e[n]) begin
            $display("FAIL rnd_rsp%0d c%0d got d=%h e=%b want d=%h e=%b", n, cyc, rsp_d(n), rsp_e(n),
                     exp_d[n], exp_e[n]);
            miscompares++;
          end
        end
      end
      @(posedge clk); #1;
      if (acc) begin
        owner = w;
        exp_e[w] = misal(mm[w], a[w]);
        exp_d[w] = we[w] ? 32'h0 : model_load(mm[w], a[w], sx[w]);
        if (we[w]) model_store(mm[w], a[w], d[w]);
        pend[w] = 1'b0;
        drop_req(w);
        pref = (w == 0);
        busy = 2;
      end else if (busy > 0) begin
        busy--;
      end
    end
    drop_req(0);
    drop_req(1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_byte_sext();
    test_round_robin();
    test_drop_valid();
    test_reset_mid_access();
    test_misalign();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
